// File: rtl/tinychip_pkg.sv
// Shared types and constants for the tinychip program-flow control blocks.
package tinychip_pkg;

  localparam int PC_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: pointer is reset, storage is plain registers.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_m1;

  assign sp_m1    = sp - PW'(1);
  assign top_data = mem[sp_m1[AW-1:0]];
  assign full     = (sp == PW'(DEPTH));
  assign empty    = (sp == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sp <= '0;
    else if (clear) sp <= '0;
    else if (push)  sp <= sp + PW'(1);
    else if (pop)   sp <= sp_m1;
  end

  // NOTE: storage has no reset; the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[sp[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FSM, branch-target LUT, call/return stack and PC write mux.
module pc_sequencer
  import tinychip_pkg::*;
#(
  parameter int                PC_W        = tinychip_pkg::PC_W,
  parameter int                LUT_DEPTH   = 32,
  parameter int                STACK_DEPTH = 4,
  parameter logic [PC_W-1:0]   START_ADDR  = '0,
  localparam int               IW          = $clog2(LUT_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            br_req,
  input  logic            br_cond,
  input  logic            call_req,
  input  logic            ret_req,
  input  logic [IW-1:0]   br_idx,
  input  logic [PC_W-1:0] cur_pc,
  input  logic            lut_we,
  input  logic [IW-1:0]   lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic            pc_write,
  output logic [PC_W-1:0] pc_target,
  output logic            running,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_LOAD = 2'(LOAD);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] lut_rdata;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] stack_top;
  logic            stack_full, stack_empty;
  logic            push, pop, set_err, clr;
  logic            idle_or_done;

  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign lut_rdata    = lut[br_idx];
  assign ret_addr     = cur_pc + PC_W'(1);
  assign running      = (state == ST_RUN);
  assign done         = (state == ST_DONE);

  // A hold is an explicit reload of cur_pc, since the PC increments whenever write is low.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b1;
    pc_target = cur_pc;
    push      = 1'b0;
    pop       = 1'b0;
    set_err   = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          clr       = 1'b1;
        end
      end
      ST_LOAD: begin
        pc_target = START_ADDR;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt = ST_DONE;
        end else if (stall) begin
          state_nxt = ST_RUN;
        end else if (ret_req) begin
          if (stack_empty) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            pop       = 1'b1;
            pc_target = stack_top;
          end
        end else if (call_req) begin
          if (stack_full) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            push      = 1'b1;
            pc_target = lut_rdata;
          end
        end else if (br_req && br_cond) begin
          pc_target = lut_rdata;
        end else begin
          pc_write = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (clr)     err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end

  // Targets are programmable only while the core is not executing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_we && idle_or_done) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clr),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule
